// File: rtl/bird_motion_ctrl.sv
// Bird vertical physics: flap/gravity integration of a signed velocity into the
// bird's top-edge row, sequenced by a READY/FLY/DEAD/LANDED state machine.
module bird_motion_ctrl #(
  parameter int START_Y  = 215,
  parameter int SCREEN_H = 480,
  parameter int BIRD_H   = 25,
  parameter int JUMP_VEL = 6,
  parameter int MAX_FALL = 8,
  parameter int GRAV_DIV = 4
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tick,
  input  logic       jump,
  input  logic       sw,
  input  logic       isDone,
  output logic [8:0] bird_pos_y,
  output logic [4:0] bird_vel,
  output logic       flap,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_READY  = 2'b00,
    S_FLY    = 2'b01,
    S_DEAD   = 2'b10,
    S_LANDED = 2'b11
  } state_t;

  localparam int G_W = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  localparam logic [8:0]        POS_START = 9'(START_Y);
  localparam logic [8:0]        POS_MAX   = 9'(SCREEN_H - BIRD_H);
  localparam logic signed [10:0] POS_MAX_S = 11'(SCREEN_H - BIRD_H);
  localparam logic signed [4:0]  JUMP_V    = -(5'(JUMP_VEL));
  localparam logic signed [4:0]  MAX_FALL_V = 5'(MAX_FALL);
  localparam logic [G_W-1:0]     G_LAST    = G_W'(GRAV_DIV - 1);

  state_t              st_q, st_d;
  logic [8:0]          pos_q, pos_d;
  logic signed [4:0]   vel_q, vel_d;
  logic [G_W-1:0]      g_q, g_d;
  logic                pend_q, pend_d;
  logic                flap_q, flap_d;
  logic                jump_q;

  logic                jump_edge;
  logic                g_last;
  logic signed [10:0]  nxt;
  logic signed [4:0]   grav_vel;

  assign jump_edge = jump & ~jump_q;
  assign g_last    = (g_q == G_LAST);
  // Position step always uses the velocity held before this tick's update.
  assign nxt       = $signed({2'b00, pos_q}) + $signed({{6{vel_q[4]}}, vel_q});
  assign grav_vel  = (vel_q >= MAX_FALL_V) ? MAX_FALL_V : vel_q + 5'sd1;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st_q   <= S_READY;
      pos_q  <= POS_START;
      vel_q  <= '0;
      g_q    <= '0;
      pend_q <= 1'b0;
      flap_q <= 1'b0;
      jump_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      pos_q  <= pos_d;
      vel_q  <= vel_d;
      g_q    <= g_d;
      pend_q <= pend_d;
      flap_q <= flap_d;
      jump_q <= jump;
    end
  end

  always_comb begin
    st_d   = st_q;
    pos_d  = pos_q;
    vel_d  = vel_q;
    g_d    = g_q;
    pend_d = pend_q;
    flap_d = 1'b0;
    unique case (st_q)
      S_READY: begin
        if (jump_edge || sw) begin
          st_d   = S_FLY;
          pend_d = 1'b1;
        end
      end
      S_FLY: begin
        if (isDone) begin
          st_d   = S_DEAD;
          vel_d  = '0;
          pend_d = 1'b0;
          g_d    = '0;
        end else begin
          if (tick) begin
            if (pend_q || sw) begin
              vel_d  = JUMP_V;
              g_d    = '0;
              flap_d = 1'b1;
              pend_d = 1'b0;
            end else if (g_last) begin
              g_d   = '0;
              vel_d = grav_vel;
            end else begin
              g_d = g_q + 1'b1;
            end
            // Hitting a screen edge kills all motion, overriding the velocity update.
            if (nxt < 0) begin
              pos_d = '0;
              vel_d = '0;
            end else if (nxt > POS_MAX_S) begin
              pos_d = POS_MAX;
              vel_d = '0;
            end else begin
              pos_d = nxt[8:0];
            end
          end
          if (jump_edge) pend_d = 1'b1;
        end
      end
      S_DEAD: begin
        if (tick) begin
          if (g_last) begin
            g_d   = '0;
            vel_d = grav_vel;
          end else begin
            g_d = g_q + 1'b1;
          end
          if (nxt >= POS_MAX_S) begin
            pos_d = POS_MAX;
            vel_d = '0;
            st_d  = S_LANDED;
          end else if (nxt < 0) begin
            pos_d = '0;
            vel_d = '0;
          end else begin
            pos_d = nxt[8:0];
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign bird_pos_y = pos_q;
  assign bird_vel   = vel_q;
  assign flap       = flap_q;
  assign state      = st_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Directed bench for bird_motion_ctrl: start, gravity, edge clamps, hold-to-flap,
// death fall and landing, with hand-computed positions and velocities.
module tb_bird_motion_ctrl;

  logic       clk = 1'b0;
  logic       clr, tick, jump, sw, isDone;
  logic [8:0] bird_pos_y;
  logic [4:0] bird_vel;
  logic       flap;
  logic [1:0] state;

  int n_cmp = 0;
  int n_fail = 0;
  int flap_cnt = 0;
  int c0;

  bird_motion_ctrl dut (
    .clk(clk), .clr(clr), .tick(tick), .jump(jump), .sw(sw), .isDone(isDone),
    .bird_pos_y(bird_pos_y), .bird_vel(bird_vel), .flap(flap), .state(state)
  );

  always #5 clk = ~clk;

  // flap is high for exactly one cycle, so one negedge sees each pulse.
  always @(negedge clk) if (flap === 1'b1) flap_cnt++;

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    jump = 1'b0; sw = 1'b0; isDone = 1'b0; tick = 1'b0; clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
    n_cmp++; if (bird_pos_y !== 9'd215) begin n_fail++; $display("FAIL reset_pos got %0d exp 215", bird_pos_y); end
    n_cmp++; if (bird_vel !== 5'd0) begin n_fail++; $display("FAIL reset_vel got %0d exp 0", $signed(bird_vel)); end
    n_cmp++; if (flap !== 1'b0) begin n_fail++; $display("FAIL reset_flap got %0b exp 0", flap); end
    @(negedge clk) clr = 1'b0;
    do_tick();
    n_cmp++; if (bird_pos_y !== 9'd215 || state !== 2'b00) begin n_fail++; $display("FAIL ready_ignores_tick got pos %0d state %0d exp 215/0", bird_pos_y, state); end
  endtask

  task automatic test_start();
    @(negedge clk) jump = 1'b1;
    @(negedge clk);
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL start_state got %0d exp 1", state); end
    do_tick();
    n_cmp++; if (flap !== 1'b1) begin n_fail++; $display("FAIL start_flap got %0b exp 1", flap); end
    n_cmp++; if (bird_pos_y !== 9'd215) begin n_fail++; $display("FAIL start_pos got %0d exp 215", bird_pos_y); end
    n_cmp++; if ($signed(bird_vel) !== -6) begin n_fail++; $display("FAIL start_vel got %0d exp -6", $signed(bird_vel)); end
    jump = 1'b0;
    @(negedge clk);
    n_cmp++; if (flap !== 1'b0) begin n_fail++; $display("FAIL start_flap_width got %0b exp 0", flap); end
    do_tick();
    n_cmp++; if (bird_pos_y !== 9'd209) begin n_fail++; $display("FAIL start_pos2 got %0d exp 209", bird_pos_y); end
  endtask

  task automatic test_gravity();
    run_ticks(23);
    n_cmp++; if (bird_pos_y !== 9'd131 || bird_vel !== 5'd0) begin n_fail++; $display("FAIL apex got pos %0d vel %0d exp 131/0", bird_pos_y, $signed(bird_vel)); end
    run_ticks(3);
    n_cmp++; if (bird_vel !== 5'd0) begin n_fail++; $display("FAIL grav_tick3_vel got %0d exp 0", $signed(bird_vel)); end
    do_tick();
    n_cmp++; if (bird_vel !== 5'd1 || bird_pos_y !== 9'd131) begin n_fail++; $display("FAIL grav_tick4 got vel %0d pos %0d exp 1/131", $signed(bird_vel), bird_pos_y); end
    run_ticks(4);
    n_cmp++; if (bird_vel !== 5'd2 || bird_pos_y !== 9'd135) begin n_fail++; $display("FAIL grav_tick8 got vel %0d pos %0d exp 2/135", $signed(bird_vel), bird_pos_y); end
  endtask

  task automatic test_floor();
    run_ticks(50);
    n_cmp++; if (bird_pos_y !== 9'd451 || bird_vel !== 5'd8) begin n_fail++; $display("FAIL pre_floor got pos %0d vel %0d exp 451/8", bird_pos_y, $signed(bird_vel)); end
    do_tick();
    n_cmp++; if (bird_pos_y !== 9'd455 || bird_vel !== 5'd0) begin n_fail++; $display("FAIL floor_clamp got pos %0d vel %0d exp 455/0", bird_pos_y, $signed(bird_vel)); end
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL floor_state got %0d exp 1", state); end
  endtask

  task automatic test_hold();
    do_reset();
    c0 = flap_cnt;
    @(negedge clk) sw = 1'b1;
    @(negedge clk);
    n_cmp++; if (state !== 2'b01) begin n_fail++; $display("FAIL hold_state got %0d exp 1", state); end
    do_tick();
    n_cmp++; if (flap !== 1'b1 || $signed(bird_vel) !== -6 || bird_pos_y !== 9'd215) begin n_fail++; $display("FAIL hold_t1 got flap %0b vel %0d pos %0d exp 1/-6/215", flap, $signed(bird_vel), bird_pos_y); end
    do_tick();
    n_cmp++; if (flap !== 1'b1 || $signed(bird_vel) !== -6 || bird_pos_y !== 9'd209) begin n_fail++; $display("FAIL hold_t2 got flap %0b vel %0d pos %0d exp 1/-6/209", flap, $signed(bird_vel), bird_pos_y); end
    do_tick();
    n_cmp++; if (flap !== 1'b1 || $signed(bird_vel) !== -6 || bird_pos_y !== 9'd203) begin n_fail++; $display("FAIL hold_t3 got flap %0b vel %0d pos %0d exp 1/-6/203", flap, $signed(bird_vel), bird_pos_y); end
    // Asynchronous reset mid-flight, while a flap pulse is still high.
    #2 clr = 1'b1; sw = 1'b0;
    #1;
    n_cmp++; if (state !== 2'b00 || bird_pos_y !== 9'd215) begin n_fail++; $display("FAIL midreset_state_pos got %0d/%0d exp 0/215", state, bird_pos_y); end
    n_cmp++; if (bird_vel !== 5'd0 || flap !== 1'b0) begin n_fail++; $display("FAIL midreset_vel_flap got %0d/%0b exp 0/0", $signed(bird_vel), flap); end
    @(negedge clk) clr = 1'b0;
    #1;
    n_cmp++; if (flap_cnt - c0 !== 3) begin n_fail++; $display("FAIL hold_flap_count got %0d exp 3", flap_cnt - c0); end
  endtask

  task automatic test_jump_hold();
    do_reset();
    c0 = flap_cnt;
    @(negedge clk) jump = 1'b1;
    run_ticks(10);
    @(negedge clk);
    #1;
    n_cmp++; if (flap_cnt - c0 !== 1) begin n_fail++; $display("FAIL jump_held_flaps got %0d exp 1", flap_cnt - c0); end
    n_cmp++; if (bird_pos_y !== 9'd167 || $signed(bird_vel) !== -4) begin n_fail++; $display("FAIL jump_held_motion got pos %0d vel %0d exp 167/-4", bird_pos_y, $signed(bird_vel)); end
    jump = 1'b0;
  endtask

  task automatic test_ceiling();
    do_reset();
    @(negedge clk) sw = 1'b1;
    run_ticks(33);
    n_cmp++; if (bird_pos_y !== 9'd23 || $signed(bird_vel) !== -6) begin n_fail++; $display("FAIL climb got pos %0d vel %0d exp 23/-6", bird_pos_y, $signed(bird_vel)); end
    sw = 1'b0;
    run_ticks(3);
    n_cmp++; if (bird_pos_y !== 9'd5 || $signed(bird_vel) !== -6) begin n_fail++; $display("FAIL pre_ceiling got pos %0d vel %0d exp 5/-6", bird_pos_y, $signed(bird_vel)); end
    do_tick();
    n_cmp++; if (bird_pos_y !== 9'd0 || bird_vel !== 5'd0) begin n_fail++; $display("FAIL ceiling_clamp got pos %0d vel %0d exp 0/0", bird_pos_y, $signed(bird_vel)); end
    n_cmp++; if (state !== 2'b01 || flap !== 1'b0) begin n_fail++; $display("FAIL ceiling_state got %0d flap %0b exp 1/0", state, flap); end
  endtask

  task automatic test_death();
    do_reset();
    @(negedge clk) jump = 1'b1;
    @(negedge clk) jump = 1'b0;
    run_ticks(3);
    @(negedge clk) begin isDone = 1'b1; tick = 1'b1; end
    @(negedge clk) tick = 1'b0;
    n_cmp++; if (state !== 2'b10 || bird_pos_y !== 9'd203) begin n_fail++; $display("FAIL death_entry got state %0d pos %0d exp 2/203", state, bird_pos_y); end
    n_cmp++; if (bird_vel !== 5'd0 || flap !== 1'b0) begin n_fail++; $display("FAIL death_vel got %0d flap %0b exp 0/0", $signed(bird_vel), flap); end
    run_ticks(4);
    n_cmp++; if (bird_pos_y !== 9'd203 || bird_vel !== 5'd1) begin n_fail++; $display("FAIL dead_grav got pos %0d vel %0d exp 203/1", bird_pos_y, $signed(bird_vel)); end
    jump = 1'b1; sw = 1'b1;
    do_tick();
    n_cmp++; if (bird_pos_y !== 9'd204 || bird_vel !== 5'd1 || flap !== 1'b0) begin n_fail++; $display("FAIL dead_ignores_input got pos %0d vel %0d flap %0b exp 204/1/0", bird_pos_y, $signed(bird_vel), flap); end
    jump = 1'b0; sw = 1'b0;
    run_ticks(44);
    n_cmp++; if (state !== 2'b10 || bird_pos_y !== 9'd451 || bird_vel !== 5'd8) begin n_fail++; $display("FAIL dead_fall got state %0d pos %0d vel %0d exp 2/451/8", state, bird_pos_y, $signed(bird_vel)); end
    do_tick();
    n_cmp++; if (state !== 2'b11 || bird_pos_y !== 9'd455 || bird_vel !== 5'd0) begin n_fail++; $display("FAIL landed got state %0d pos %0d vel %0d exp 3/455/0", state, bird_pos_y, $signed(bird_vel)); end
    c0 = flap_cnt;
    isDone = 1'b0; jump = 1'b1; sw = 1'b1;
    run_ticks(3);
    #1;
    n_cmp++; if (state !== 2'b11 || bird_pos_y !== 9'd455 || bird_vel !== 5'd0) begin n_fail++; $display("FAIL landed_frozen got state %0d pos %0d vel %0d exp 3/455/0", state, bird_pos_y, $signed(bird_vel)); end
    n_cmp++; if (flap_cnt - c0 !== 0) begin n_fail++; $display("FAIL landed_no_flap got %0d exp 0", flap_cnt - c0); end
    jump = 1'b0; sw = 1'b0;
  endtask

  initial begin
    clr = 1'b1; tick = 1'b0; jump = 1'b0; sw = 1'b0; isDone = 1'b0;
    test_reset();
    test_start();
    test_gravity();
    test_floor();
    test_hold();
    test_jump_hold();
    test_ceiling();
    test_death();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
